// File: rtl/cache_pkg.sv
// Shared definitions for the trace front-end and the split L1 caches:
// opcodes, dispatcher FSM states, MESI line states and opcode routing.
package cache_pkg;

    localparam logic [3:0] OP_RD_D  = 4'd0;
    localparam logic [3:0] OP_WR_D  = 4'd1;
    localparam logic [3:0] OP_RD_I  = 4'd2;
    localparam logic [3:0] OP_INV   = 4'd3;
    localparam logic [3:0] OP_SNOOP = 4'd4;
    localparam logic [3:0] OP_CLR   = 4'd8;
    localparam logic [3:0] OP_PRINT = 4'd9;

    typedef enum logic [1:0] {RUN, DRAIN, FINAL, DONE} disp_state_t;

    typedef enum logic [1:0] {INVALID, SHARED, EXCLUSIVE, MODIFIED} states;

    // Returns {to_icache, to_dcache}; 2'b00 marks an opcode that is dropped.
    function automatic logic [1:0] op_route(input logic [3:0] n);
        case (n)
            OP_RD_D, OP_WR_D, OP_INV, OP_SNOOP: op_route = 2'b01;
            OP_RD_I:                            op_route = 2'b10;
            OP_CLR, OP_PRINT:                   op_route = 2'b11;
            default:                            op_route = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO; natural-wrap pointers, separate count register for full/empty.
module trace_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_empty,
    output logic         o_full
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = PW + 1;

    logic [W-1:0]    r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNTW'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNTW'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CNTW'(1);
        end
    end

endmodule

// File: rtl/trace_dispatcher.sv
// Buffers trace records and routes them to the D/I caches with per-opcode stats;
// at end of trace drains, optionally broadcasts a print, then raises done.
module trace_dispatcher
    import cache_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned CW    = 32,
    parameter int unsigned MODE  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_n,
    input  logic [AW-1:0] cmd_addr,
    input  logic          trace_eof,
    output logic          d_valid,
    output logic [3:0]    d_n,
    output logic [AW-1:0] d_addr,
    output logic          i_valid,
    output logic [3:0]    i_n,
    output logic [AW-1:0] i_addr,
    output logic [CW-1:0] cnt_rd,
    output logic [CW-1:0] cnt_wr,
    output logic [CW-1:0] cnt_if,
    output logic [CW-1:0] cnt_l2,
    output logic [CW-1:0] cnt_bad,
    output logic          done,
    output logic [1:0]    dbg_state
);

    disp_state_t   r_state;
    logic          r_d_valid, r_i_valid, r_done;
    logic [3:0]    r_d_n, r_i_n;
    logic [AW-1:0] r_d_addr, r_i_addr;
    logic [CW-1:0] r_cnt_rd, r_cnt_wr, r_cnt_if, r_cnt_l2, r_cnt_bad;

    logic          w_push, w_pop, w_empty, w_full;
    logic [AW+3:0] w_head;
    logic [3:0]    w_head_n;
    logic [AW-1:0] w_head_addr;
    logic [1:0]    w_route;

    // cmd_valid/cmd_ready: a record transfers on any cycle where both are high;
    // cmd_ready depends only on registered state, never on cmd_valid.
    assign cmd_ready   = !w_full && (r_state == RUN);
    assign w_push      = cmd_valid && cmd_ready;
    assign w_pop       = !w_empty && ((r_state == RUN) || (r_state == DRAIN));
    assign w_head_n    = w_head[AW+3:AW];
    assign w_head_addr = w_head[AW-1:0];
    assign w_route     = op_route(w_head_n);

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + 4)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({cmd_n, cmd_addr}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= RUN;
            r_d_valid <= 1'b0;
            r_i_valid <= 1'b0;
            r_d_n     <= '0;
            r_i_n     <= '0;
            r_d_addr  <= '0;
            r_i_addr  <= '0;
            r_cnt_rd  <= '0;
            r_cnt_wr  <= '0;
            r_cnt_if  <= '0;
            r_cnt_l2  <= '0;
            r_cnt_bad <= '0;
            r_done    <= 1'b0;
        end else begin
            r_d_valid <= 1'b0;
            r_i_valid <= 1'b0;
            if (w_pop) begin
                if (w_route[0]) begin
                    r_d_valid <= 1'b1;
                    r_d_n     <= w_head_n;
                    r_d_addr  <= w_head_addr;
                end
                if (w_route[1]) begin
                    r_i_valid <= 1'b1;
                    r_i_n     <= w_head_n;
                    r_i_addr  <= w_head_addr;
                end
                case (w_head_n)
                    OP_RD_D:          r_cnt_rd  <= r_cnt_rd + CW'(1);
                    OP_WR_D:          r_cnt_wr  <= r_cnt_wr + CW'(1);
                    OP_RD_I:          r_cnt_if  <= r_cnt_if + CW'(1);
                    OP_INV, OP_SNOOP: r_cnt_l2  <= r_cnt_l2 + CW'(1);
                    OP_CLR, OP_PRINT: ;
                    default:          r_cnt_bad <= r_cnt_bad + CW'(1);
                endcase
            end
            case (r_state)
                RUN:   if (trace_eof) r_state <= DRAIN;
                // Empty FIFO means no pop can happen in this cycle either.
                DRAIN: if (w_empty) r_state <= (MODE == 0) ? FINAL : DONE;
                FINAL: begin
                    r_d_valid <= 1'b1;
                    r_i_valid <= 1'b1;
                    r_d_n     <= OP_PRINT;
                    r_i_n     <= OP_PRINT;
                    r_d_addr  <= '0;
                    r_i_addr  <= '0;
                    r_state   <= DONE;
                end
                DONE:  r_done <= 1'b1;
                default: r_state <= RUN;
            endcase
        end
    end

    assign d_valid   = r_d_valid;
    assign d_n       = r_d_n;
    assign d_addr    = r_d_addr;
    assign i_valid   = r_i_valid;
    assign i_n       = r_i_n;
    assign i_addr    = r_i_addr;
    assign cnt_rd    = r_cnt_rd;
    assign cnt_wr    = r_cnt_wr;
    assign cnt_if    = r_cnt_if;
    assign cnt_l2    = r_cnt_l2;
    assign cnt_bad   = r_cnt_bad;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_trace_dispatcher.sv
// Directed bench for trace_dispatcher: MODE=0 main instance plus a MODE=1 twin for the EOF path.
module tb_trace_dispatcher;

    localparam int AW = 32;
    localparam int CW = 32;

    logic          clk, rst, cmd_valid, trace_eof;
    logic [3:0]    cmd_n;
    logic [AW-1:0] cmd_addr;

    logic          cmd_ready, d_valid, i_valid, done;
    logic [3:0]    d_n, i_n;
    logic [AW-1:0] d_addr, i_addr;
    logic [CW-1:0] cnt_rd, cnt_wr, cnt_if, cnt_l2, cnt_bad;
    logic [1:0]    dbg_state;

    logic          m1_cmd_ready, m1_d_valid, m1_i_valid, m1_done;
    logic [3:0]    m1_d_n, m1_i_n;
    logic [AW-1:0] m1_d_addr, m1_i_addr;
    logic [CW-1:0] m1_cnt_rd, m1_cnt_wr, m1_cnt_if, m1_cnt_l2, m1_cnt_bad;
    logic [1:0]    m1_dbg_state;

    logic [AW+3:0] exp_q[$];
    logic [AW+3:0] d_log[$];
    logic [AW+3:0] i_log[$];
    int            m1_print;
    int            n_checks = 0;
    int            n_fail   = 0;

    trace_dispatcher #(.DEPTH(4), .AW(AW), .CW(CW), .MODE(0)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_n(cmd_n), .cmd_addr(cmd_addr), .trace_eof(trace_eof),
        .d_valid(d_valid), .d_n(d_n), .d_addr(d_addr),
        .i_valid(i_valid), .i_n(i_n), .i_addr(i_addr),
        .cnt_rd(cnt_rd), .cnt_wr(cnt_wr), .cnt_if(cnt_if), .cnt_l2(cnt_l2),
        .cnt_bad(cnt_bad), .done(done), .dbg_state(dbg_state)
    );

    trace_dispatcher #(.DEPTH(4), .AW(AW), .CW(CW), .MODE(1)) dut_m1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(m1_cmd_ready),
        .cmd_n(cmd_n), .cmd_addr(cmd_addr), .trace_eof(trace_eof),
        .d_valid(m1_d_valid), .d_n(m1_d_n), .d_addr(m1_d_addr),
        .i_valid(m1_i_valid), .i_n(m1_i_n), .i_addr(m1_i_addr),
        .cnt_rd(m1_cnt_rd), .cnt_wr(m1_cnt_wr), .cnt_if(m1_cnt_if), .cnt_l2(m1_cnt_l2),
        .cnt_bad(m1_cnt_bad), .done(m1_done), .dbg_state(m1_dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (d_valid) d_log.push_back({d_n, d_addr});
        if (i_valid) i_log.push_back({i_n, i_addr});
        if ((m1_d_valid && m1_d_n == 4'd9) || (m1_i_valid && m1_i_n == 4'd9)) m1_print++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; cmd_valid = 1'b0; cmd_n = '0; cmd_addr = '0; trace_eof = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        d_log.delete(); i_log.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_n = '0; cmd_addr = '0; trace_eof = 1'b0;
        #7; rst = 1'b0; #2;
        n_checks++;
        if ({d_valid, i_valid, d_n, i_n, done} !== 11'b0) begin
            n_fail++; $display("FAIL reset_ctrl got=%h exp=0", {d_valid, i_valid, d_n, i_n, done});
        end
        n_checks++;
        if ({d_addr, i_addr} !== 64'b0) begin
            n_fail++; $display("FAIL reset_addr got=%h exp=0", {d_addr, i_addr});
        end
        n_checks++;
        if ({cnt_rd, cnt_wr, cnt_if, cnt_l2, cnt_bad} !== 160'b0) begin
            n_fail++; $display("FAIL reset_counters got=%h exp=0", {cnt_rd, cnt_wr, cnt_if, cnt_l2, cnt_bad});
        end
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=1", cmd_ready);
        end
        n_checks++;
        if (dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        cmd_valid = 1'b1; cmd_n = 4'd0; cmd_addr = 32'h0000_1040;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (d_valid !== 1'b0) begin
            n_fail++; $display("FAIL read_early got=%b exp=0", d_valid);
        end
        tick();
        n_checks++;
        if ({d_valid, i_valid, d_n, d_addr} !== {1'b1, 1'b0, 4'd0, 32'h0000_1040}) begin
            n_fail++; $display("FAIL read_strobe got=%b%b n=%0d addr=%h exp=10 n=0 addr=00001040",
                               d_valid, i_valid, d_n, d_addr);
        end
        n_checks++;
        if (cnt_rd !== 32'd1) begin
            n_fail++; $display("FAIL read_cnt got=%0d exp=1", cnt_rd);
        end
        tick();
        n_checks++;
        if (d_valid !== 1'b0) begin
            n_fail++; $display("FAIL read_width got=%b exp=0", d_valid);
        end
    endtask

    task automatic test_fetch_clear();
        do_reset();
        cmd_valid = 1'b1; cmd_n = 4'd2; cmd_addr = 32'h400;
        tick();
        cmd_n = 4'd8; cmd_addr = 32'h0;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if ({d_valid, i_valid, i_n, i_addr} !== {1'b0, 1'b1, 4'd2, 32'h400}) begin
            n_fail++; $display("FAIL fetch_strobe got=%b%b n=%0d addr=%h exp=01 n=2 addr=00000400",
                               d_valid, i_valid, i_n, i_addr);
        end
        tick();
        n_checks++;
        if ({d_valid, i_valid, d_n, i_n, d_addr, i_addr} !== {2'b11, 4'd8, 4'd8, 64'b0}) begin
            n_fail++; $display("FAIL clear_bcast got=%b%b dn=%0d in=%0d da=%h ia=%h exp=11 8 8 0 0",
                               d_valid, i_valid, d_n, i_n, d_addr, i_addr);
        end
        n_checks++;
        if ({cnt_if, cnt_rd, cnt_bad} !== {32'd1, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL fetch_cnt got if=%0d rd=%0d bad=%0d exp=1 0 0", cnt_if, cnt_rd, cnt_bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [6];
        int drops;
        ops = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd0, 4'd1};
        drops = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cmd_valid = 1'b1; cmd_n = ops[k]; cmd_addr = 32'h100 + 32'(k * 4);
            exp_q.push_back({ops[k], 32'h100 + 32'(k * 4)});
            if (cmd_ready !== 1'b1) drops++;
            tick();
        end
        cmd_valid = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (drops !== 0) begin
            n_fail++; $display("FAIL b2b_ready got_drops=%0d exp=0", drops);
        end
        n_checks++;
        if (d_log.size() !== 6 || i_log.size() !== 0) begin
            n_fail++; $display("FAIL b2b_count got d=%0d i=%0d exp d=6 i=0", d_log.size(), i_log.size());
        end
        for (int k = 0; k < 6 && k < d_log.size(); k++) begin
            n_checks++;
            if (d_log[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL b2b_order[%0d] got=%h exp=%h", k, d_log[k], exp_q[k]);
            end
        end
        n_checks++;
        if ({cnt_rd, cnt_wr, cnt_l2} !== {32'd2, 32'd2, 32'd2}) begin
            n_fail++; $display("FAIL b2b_cnt got rd=%0d wr=%0d l2=%0d exp=2 2 2", cnt_rd, cnt_wr, cnt_l2);
        end
    endtask

    task automatic test_stall();
        do_reset();
        force dut.w_pop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1'b1; cmd_n = 4'd1; cmd_addr = 32'h200 + 32'(k);
            exp_q.push_back({4'd1, 32'h200 + 32'(k)});
            n_checks++;
            if (cmd_ready !== 1'b1) begin
                n_fail++; $display("FAIL stall_fill_ready[%0d] got=%b exp=1", k, cmd_ready);
            end
            tick();
        end
        cmd_n = 4'd0; cmd_addr = 32'h2FF;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_full_ready got=%b exp=0", cmd_ready);
        end
        tick();
        n_checks++;
        if (cmd_ready !== 1'b0 || d_log.size() !== 0) begin
            n_fail++; $display("FAIL stall_hold got ready=%b strobes=%0d exp=0 0", cmd_ready, d_log.size());
        end
        cmd_valid = 1'b0;
        release dut.w_pop;
        repeat (6) tick();
        n_checks++;
        if (d_log.size() !== 4) begin
            n_fail++; $display("FAIL stall_drain_count got=%0d exp=4", d_log.size());
        end
        for (int k = 0; k < 4 && k < d_log.size(); k++) begin
            n_checks++;
            if (d_log[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL stall_order[%0d] got=%h exp=%h", k, d_log[k], exp_q[k]);
            end
        end
        n_checks++;
        if ({cnt_wr, cnt_rd} !== {32'd4, 32'd0}) begin
            n_fail++; $display("FAIL stall_cnt got wr=%0d rd=%0d exp=4 0", cnt_wr, cnt_rd);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        cmd_valid = 1'b1; cmd_n = 4'd5; cmd_addr = 32'h300;
        tick();
        cmd_n = 4'd0; cmd_addr = 32'h304;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if ({d_valid, i_valid} !== 2'b00 || cnt_bad !== 32'd1) begin
            n_fail++; $display("FAIL illegal_drop got strobes=%b%b bad=%0d exp=00 1", d_valid, i_valid, cnt_bad);
        end
        tick();
        n_checks++;
        if ({d_valid, d_n, d_addr} !== {1'b1, 4'd0, 32'h304} || cnt_rd !== 32'd1) begin
            n_fail++; $display("FAIL illegal_next got v=%b n=%0d addr=%h rd=%0d exp=1 0 00000304 1",
                               d_valid, d_n, d_addr, cnt_rd);
        end
    endtask

    task automatic test_eof();
        do_reset();
        m1_print = 0;
        cmd_valid = 1'b1; cmd_n = 4'd0; cmd_addr = 32'h10;
        tick();
        cmd_n = 4'd2; cmd_addr = 32'h20;
        tick();
        n_checks++;
        if ({d_valid, d_addr} !== {1'b1, 32'h10}) begin
            n_fail++; $display("FAIL eof_rec0 got v=%b addr=%h exp=1 00000010", d_valid, d_addr);
        end
        cmd_n = 4'd1; cmd_addr = 32'h30; trace_eof = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if ({i_valid, i_addr, cmd_ready} !== {1'b1, 32'h20, 1'b0}) begin
            n_fail++; $display("FAIL eof_rec1 got v=%b addr=%h ready=%b exp=1 00000020 0", i_valid, i_addr, cmd_ready);
        end
        tick();
        n_checks++;
        if ({d_valid, d_n, d_addr} !== {1'b1, 4'd1, 32'h30}) begin
            n_fail++; $display("FAIL eof_rec2 got v=%b n=%0d addr=%h exp=1 1 00000030", d_valid, d_n, d_addr);
        end
        tick();
        n_checks++;
        if ({d_valid, i_valid, m1_d_valid, m1_i_valid, done, m1_done} !== 6'b0) begin
            n_fail++; $display("FAIL eof_gap got=%b exp=000000",
                               {d_valid, i_valid, m1_d_valid, m1_i_valid, done, m1_done});
        end
        tick();
        n_checks++;
        if ({d_valid, i_valid, d_n, i_n, d_addr, i_addr, done} !== {2'b11, 4'd9, 4'd9, 64'b0, 1'b0}) begin
            n_fail++; $display("FAIL eof_print got v=%b%b dn=%0d in=%0d da=%h ia=%h done=%b exp=11 9 9 0 0 0",
                               d_valid, i_valid, d_n, i_n, d_addr, i_addr, done);
        end
        n_checks++;
        if ({m1_done, m1_d_valid, m1_i_valid} !== 3'b100) begin
            n_fail++; $display("FAIL eof_mode1_done got=%b exp=100", {m1_done, m1_d_valid, m1_i_valid});
        end
        tick();
        n_checks++;
        if ({done, cmd_ready, d_valid, i_valid} !== 4'b1000 || dbg_state !== 2'd3) begin
            n_fail++; $display("FAIL eof_done got=%b state=%0d exp=1000 3", {done, cmd_ready, d_valid, i_valid}, dbg_state);
        end
        repeat (3) tick();
        n_checks++;
        if ({done, d_valid, i_valid} !== 3'b100 || m1_print !== 0) begin
            n_fail++; $display("FAIL eof_hold got=%b m1_prints=%0d exp=100 0", {done, d_valid, i_valid}, m1_print);
        end
        n_checks++;
        if ({cnt_rd, cnt_wr, cnt_if} !== {32'd1, 32'd1, 32'd1}) begin
            n_fail++; $display("FAIL eof_cnt got rd=%0d wr=%0d if=%0d exp=1 1 1", cnt_rd, cnt_wr, cnt_if);
        end
        trace_eof = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        force dut.w_pop = 1'b0;
        cmd_valid = 1'b1; cmd_n = 4'd0; cmd_addr = 32'h500;
        tick();
        cmd_addr = 32'h504;
        tick();
        cmd_valid = 1'b0;
        release dut.w_pop;
        tick();
        n_checks++;
        if ({d_valid, d_addr} !== {1'b1, 32'h500}) begin
            n_fail++; $display("FAIL rstmid_pre got v=%b addr=%h exp=1 00000500", d_valid, d_addr);
        end
        #2; rst = 1'b0; #1;
        n_checks++;
        if ({d_valid, i_valid, d_n, i_n, done, d_addr, cnt_rd} !== 75'b0) begin
            n_fail++; $display("FAIL rstmid_async got v=%b%b addr=%h rd=%0d exp=00 0 0", d_valid, i_valid, d_addr, cnt_rd);
        end
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        d_log.delete(); i_log.delete();
        repeat (4) tick();
        n_checks++;
        if (d_log.size() !== 0 || i_log.size() !== 0) begin
            n_fail++; $display("FAIL rstmid_discard got d=%0d i=%0d exp=0 0", d_log.size(), i_log.size());
        end
        n_checks++;
        if ({cnt_rd, cnt_wr, cnt_if, cnt_l2, cnt_bad} !== 160'b0) begin
            n_fail++; $display("FAIL rstmid_cnt got rd=%0d exp=0", cnt_rd);
        end
    endtask

    initial begin
        m1_print = 0;
        test_reset();
        test_single_read();
        test_fetch_clear();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_eof();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
